// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the framebuffer read scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_BURST,
    S_DRAIN
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/wb_burst_tracker.sv
// Counts requests issued and acks returned within one Wishbone burst.
module wb_burst_tracker #(
  parameter int unsigned BURST = 16,
  parameter int unsigned CW    = $clog2(BURST) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          issue,
  input  logic          ack,
  input  logic [CW-1:0] len,
  output logic          last_c,
  output logic          done_c,
  output logic          empty_c
);

  logic [CW-1:0] issued;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;

  assign out_nxt = outstanding + CW'(issue) - CW'(ack);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      issued      <= '0;
      outstanding <= '0;
    end else begin
      if (issue) issued <= issued + CW'(1);
      outstanding <= out_nxt;
    end
  end

  // empty_c already accounts for this cycle's issue/ack so the bus can be released promptly
  assign last_c  = (issued + CW'(1)) == len;
  assign done_c  = issued == len;
  assign empty_c = out_nxt == '0;

endmodule

// File: rtl/fb_read_scheduler.sv
// Sequences Wishbone pipelined burst reads of the framebuffer into the pixel FIFO,
// restarting at pixel 0 on frame_sync.
module fb_read_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned HDISP   = 800,
  parameter int unsigned VDISP   = 480,
  parameter logic [31:0] FB_BASE = 32'h0000_0000,
  parameter int unsigned BURST   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_sync,
  input  logic        fifo_walmost_full,
  output logic        fifo_write,
  output logic [31:0] fifo_wdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_stall
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned IW   = $clog2(NPIX);
  localparam int unsigned CW   = $clog2(BURST) + 1;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic          pend_q, pend_d;
  logic [CW-1:0] len_q, len_d, len_c;
  logic [31:0]   rem_c;
  logic          cyc_d, stb_d;
  logic [31:0]   adr_d;
  logic          start;
  logic          accept_c;
  logic          ack_v;
  logic          last_c, done_c, empty_c;

  function automatic logic [31:0] pix_addr(input logic [IW-1:0] i);
    return FB_BASE + 32'(i) * 32'(WORD_BYTES);
  endfunction

  assign wb_we  = 1'b0;
  assign wb_sel = 4'hF;

  assign accept_c = wb_stb && !wb_stall;
  assign ack_v    = wb_ack && ((state_q == S_BURST) || (state_q == S_DRAIN));
  assign idx_inc  = (idx_q == IW'(NPIX - 1)) ? '0 : idx_q + IW'(1);
  assign rem_c    = 32'(NPIX) - 32'(idx_q);
  assign len_c    = (rem_c < 32'(BURST)) ? CW'(rem_c) : CW'(BURST);

  wb_burst_tracker #(
    .BURST(BURST),
    .CW   (CW)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .issue  (accept_c),
    .ack    (ack_v),
    .len    (len_q),
    .last_c (last_c),
    .done_c (done_c),
    .empty_c(empty_c)
  );

  // State, pixel index and registered bus/FIFO outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      len_q      <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_adr     <= FB_BASE;
      fifo_write <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      len_q      <= len_d;
      wb_cyc     <= cyc_d;
      wb_stb     <= stb_d;
      wb_adr     <= adr_d;
      fifo_write <= ack_v;
      if (ack_v) fifo_wdata <= wb_dat_sm;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    len_d   = len_q;
    cyc_d   = wb_cyc;
    stb_d   = wb_stb;
    adr_d   = wb_adr;
    start   = 1'b0;

    // A frame_sync mid-stream is deferred until the current burst has drained
    if (frame_sync && (state_q != S_IDLE)) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_sync) begin
          idx_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!fifo_walmost_full) begin
          len_d   = len_c;
          start   = 1'b1;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = pix_addr(idx_q);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (accept_c) begin
          idx_d = idx_inc;
          adr_d = pix_addr(idx_inc);
          if (last_c) begin
            stb_d   = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (done_c && empty_c) begin
          cyc_d   = 1'b0;
          state_d = S_CHECK;
          if (pend_q || frame_sync) begin
            idx_d  = '0;
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Directed bench: instance 0 is 160x90, instance 1 is 10x3, both BURST=16,
// each with a latency-programmable Wishbone slave returning adr^DMASK.
module tb_fb_read_scheduler;

  localparam logic [31:0] DMASK = 32'hA5A5_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs    [2];
  logic       af    [2];
  logic       st    [2];
  logic [2:0] latm1 [2];
  int         tcyc = 0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int unsigned HD = (g == 0) ? 160 : 10;
    localparam int unsigned VD = (g == 0) ? 90 : 3;

    logic        cyc, stb, we, wr, ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdata, dat;
    logic        acc;

    fb_read_scheduler #(
      .HDISP  (HD),
      .VDISP  (VD),
      .FB_BASE(32'h0000_0000),
      .BURST  (16)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .frame_sync       (fs[g]),
      .fifo_walmost_full(af[g]),
      .fifo_write       (wr),
      .fifo_wdata       (wdata),
      .wb_cyc           (cyc),
      .wb_stb           (stb),
      .wb_we            (we),
      .wb_sel           (sel),
      .wb_adr           (adr),
      .wb_dat_sm        (dat),
      .wb_ack           (ack),
      .wb_stall         (st[g])
    );

    // Slave: ack arrives latm1+1 cycles after acceptance, in order
    logic [7:0]  pv = '0;
    logic [31:0] pd [8];
    assign acc = cyc && stb && !st[g];
    always @(posedge clk) begin
      for (int i = 0; i < 7; i++) begin
        pv[i] <= pv[i+1];
        pd[i] <= pd[i+1];
      end
      pv[7] <= 1'b0;
      pd[7] <= '0;
      if (acc) begin
        pv[latm1[g]] <= 1'b1;
        pd[latm1[g]] <= adr ^ DMASK;
      end
    end
    assign ack = pv[0];
    assign dat = pd[0];

    // Monitor: logs accepted addresses, FIFO words, burst lengths and event times
    logic [31:0] alog [256];
    logic [31:0] dlog [256];
    int          blog [16];
    int          acnt = 0, dcnt = 0, bcnt = 0, bcur = 0, cyc_hi = 0;
    int          last_ack_t = 0, last_wr_t = 0, fall_t = 0;
    logic        cyc_p = 1'b0;
    always @(negedge clk) begin
      if (acc) begin
        if (acnt < 256) alog[acnt] = adr;
        acnt++;
        bcur++;
      end
      if (wr) begin
        if (dcnt < 256) dlog[dcnt] = wdata;
        dcnt++;
        last_wr_t = tcyc;
      end
      if (ack) last_ack_t = tcyc;
      if (cyc) cyc_hi++;
      if (cyc_p && !cyc) begin
        fall_t = tcyc;
        if (bcnt < 16) blog[bcnt] = bcur;
        bcnt++;
        bcur = 0;
      end
      cyc_p = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int b_a, b_d, c0, k;
    logic [31:0] e;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; af[i] = 1'b0; st[i] = 1'b0; latm1[i] = 3'd0;
    end
    step(3);
    rst = 1'b0;
    step(1);

    // Reset values
    check("rst_cyc0", 32'(g_u[0].cyc), 0);
    check("rst_stb0", 32'(g_u[0].stb), 0);
    check("rst_adr0", g_u[0].adr, 0);
    check("rst_wr0", 32'(g_u[0].wr), 0);
    check("rst_wdata0", g_u[0].wdata, 0);
    check("rst_we0", 32'(g_u[0].we), 0);
    check("rst_sel0", 32'(g_u[0].sel), 32'hF);
    check("rst_we1", 32'(g_u[1].we), 0);
    check("rst_sel1", 32'(g_u[1].sel), 32'hF);
    step(5);
    check("idle_no_cyc", 32'(g_u[0].cyc_hi), 0);

    // First burst: addresses 0..60, one per cycle
    b_a = g_u[0].acnt; b_d = g_u[0].dcnt;
    fs[0] = 1'b1; step(1); fs[0] = 1'b0; step(1);
    check("b0_stb_up", 32'(g_u[0].stb), 1);
    af[0] = 1'b1;
    for (int i = 0; i < 40 && g_u[0].cyc; i++) step(1);
    step(2);
    check("b0_cyc_done", 32'(g_u[0].cyc), 0);
    check("b0_nreq", 32'(g_u[0].acnt - b_a), 16);
    check("b0_nwr", 32'(g_u[0].dcnt - b_d), 16);
    for (int i = 0; i < 16; i++) begin
      check("b0_adr", g_u[0].alog[b_a+i], 32'(4 * i));
      check("b0_data", g_u[0].dlog[b_d+i], 32'(4 * i) ^ DMASK);
    end
    check("b0_cyc_fall", 32'(g_u[0].fall_t - g_u[0].last_ack_t), 1);
    check("b0_wr_lat", 32'(g_u[0].last_wr_t - g_u[0].last_ack_t), 1);
    check("b0_blen", 32'(g_u[0].blog[0]), 16);

    // Almost-full holds off requests; release starts the next burst at idx 16
    c0 = g_u[0].cyc_hi;
    step(20);
    check("af_hold", 32'(g_u[0].cyc_hi - c0), 0);
    b_a = g_u[0].acnt; b_d = g_u[0].dcnt;
    af[0] = 1'b0;
    k = 0;
    do begin step(1); k++; end while (!g_u[0].stb && k < 2);
    check("af_stb_rise", 32'(g_u[0].stb), 1);
    check("af_adr", g_u[0].adr, 64);

    // frame_sync at idx 40 defers the restart until the burst ending at 188
    for (int i = 0; i < 100 && !(g_u[0].stb && g_u[0].adr == 32'd160); i++) step(1);
    check("fs_at_idx40", g_u[0].adr, 160);
    fs[0] = 1'b1; step(1); fs[0] = 1'b0;

    // Stall the 5th request of the restarted burst for 3 cycles
    for (int i = 0; i < 100 && !(g_u[0].stb && g_u[0].adr == 32'd16); i++) step(1);
    check("stall_at16", g_u[0].adr, 16);
    st[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_adr", g_u[0].adr, 16);
      check("stall_stb", 32'(g_u[0].stb), 1);
    end
    st[0] = 1'b0;
    af[0] = 1'b1;
    for (int i = 0; i < 60 && g_u[0].cyc; i++) step(1);
    step(2);
    check("seq_cyc_done", 32'(g_u[0].cyc), 0);
    check("seq_nreq", 32'(g_u[0].acnt - b_a), 48);
    check("seq_nwr", 32'(g_u[0].dcnt - b_d), 48);
    for (int i = 0; i < 48; i++) begin
      e = (i < 32) ? 32'(64 + 4 * i) : 32'(4 * (i - 32));
      check("seq_adr", g_u[0].alog[b_a+i], e);
      check("seq_data", g_u[0].dlog[b_d+i], e ^ DMASK);
    end

    // Reset mid-burst with five requests outstanding
    latm1[0] = 3'd5;
    b_d = g_u[0].dcnt;
    af[0] = 1'b0;
    k = 0;
    while (!g_u[0].stb && k < 3) begin step(1); k++; end
    check("rstmid_stb_up", 32'(g_u[0].stb), 1);
    step(4);
    rst = 1'b1;
    step(1);
    check("rstmid_cyc", 32'(g_u[0].cyc), 0);
    check("rstmid_stb", 32'(g_u[0].stb), 0);
    check("rstmid_adr", g_u[0].adr, 0);
    rst = 1'b0;
    c0 = g_u[0].cyc_hi;
    step(20);
    check("rstmid_no_wr", 32'(g_u[0].dcnt - b_d), 0);
    check("rstmid_no_req", 32'(g_u[0].cyc_hi - c0), 0);
    latm1[0] = 3'd0;
    fs[0] = 1'b1; step(1); fs[0] = 1'b0; step(1);
    check("rstmid_restart_stb", 32'(g_u[0].stb), 1);
    check("rstmid_restart_adr", g_u[0].adr, 0);
    af[0] = 1'b1;
    for (int i = 0; i < 60 && g_u[0].cyc; i++) step(1);

    // Small frame (30 pixels): bursts of 16 and 14, then wrap to FB_BASE
    b_a = g_u[1].acnt; b_d = g_u[1].dcnt;
    fs[1] = 1'b1; step(1); fs[1] = 1'b0;
    for (int i = 0; i < 200 && (g_u[1].acnt - b_a) < 31; i++) step(1);
    af[1] = 1'b1;
    for (int i = 0; i < 60 && g_u[1].cyc; i++) step(1);
    step(2);
    check("wrap_cyc_done", 32'(g_u[1].cyc), 0);
    check("wrap_nreq", 32'(g_u[1].acnt - b_a), 46);
    check("wrap_blen0", 32'(g_u[1].blog[0]), 16);
    check("wrap_blen1", 32'(g_u[1].blog[1]), 14);
    check("wrap_blen2", 32'(g_u[1].blog[2]), 16);
    for (int i = 0; i < 46; i++) begin
      e = (i < 30) ? 32'(4 * i) : 32'(4 * (i - 30));
      check("wrap_adr", g_u[1].alog[b_a+i], e);
      check("wrap_data", g_u[1].dlog[b_d+i], e ^ DMASK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
